arb_client: RTL

Requester-side controller for the single-resource arbiter handshake (`req`/`gnt`/`done`/`dly`/`reset`/`tout`). It accepts a local transfer command, requests the resource, runs the transfer for a programmed number of granted cycles, and releases the resource, with an optional post-transfer hold. It also recovers from an arbiter timeout (`tout`) by issuing the arbiter `reset`. It sits between a local master and the arbiter, one instance per client.

---
 rtl/arb_client.sv | 120 ++++++++++++
 1 files changed

// File: rtl/arb_client.sv
// arb_client: requester-side controller for the req/gnt/done/dly/reset/tout arbiter handshake.
module arb_client #(
  parameter int LEN_W    = 8,
  parameter int HOLD_W   = 4,
  parameter int GNT_WAIT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [HOLD_W-1:0] hold,
  output logic              busy,
  output logic              xfer_en,
  output logic              complete,
  output logic [1:0]        err,
  output logic              req,
  input  logic              gnt,
  output logic              done,
  output logic              dly,
  output logic              reset,
  input  logic              tout
);
  typedef enum logic [2:0] {IDLE, REQ, XFER, FIN, HOLD, REL} state_t;
  state_t r_state, w_nxt;
  logic [LEN_W-1:0]  r_cnt, w_cnt;
  logic [HOLD_W-1:0] r_hold, w_hold, r_hcnt, w_hcnt;
  logic [31:0]       r_wait, w_wait;
  logic [1:0]        r_err, w_err;
  logic              r_abort, w_abort, w_xfer;
  logic              r_busy, r_xfer, r_complete, r_req, r_done, r_dly, r_reset;
  // Outputs are registered from the next-state decode, so each one lines up with the state it belongs to.
  always_comb begin
    w_nxt   = r_state;
    w_cnt   = r_cnt;
    w_hold  = r_hold;
    w_hcnt  = r_hcnt;
    w_wait  = r_wait;
    w_err   = r_err;
    w_abort = r_abort;
    w_xfer  = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_nxt   = REQ;
        w_cnt   = len;
        w_hold  = hold;
        w_err   = 2'b00;
        w_abort = 1'b0;
        w_wait  = '0;
      end
      REQ: if (gnt) begin
        w_nxt  = (r_cnt == '0) ? FIN : XFER;
        w_xfer = (r_cnt != '0);
        w_cnt  = (r_cnt == '0) ? r_cnt : r_cnt - LEN_W'(1);
      end else if (GNT_WAIT != 0 && r_wait == 32'(GNT_WAIT - 1)) begin
        w_nxt = REL;
        w_err = 2'b10;
      end else begin
        w_wait = r_wait + 32'd1;
      end
      XFER: if (tout) begin
        w_nxt   = FIN;
        w_abort = 1'b1;
        w_err   = 2'b01;
      end else if (r_cnt == '0) begin
        w_nxt = FIN;
      end else if (gnt) begin
        w_xfer = 1'b1;
        w_cnt  = r_cnt - LEN_W'(1);
      end
      FIN: begin
        w_nxt  = (r_hold > HOLD_W'(1)) ? HOLD : REL;
        w_hcnt = r_hold - HOLD_W'(2);
      end
      HOLD: if (r_hcnt == '0) w_nxt = REL; else w_hcnt = r_hcnt - HOLD_W'(1);
      REL: if (!gnt) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_hold     <= '0;
      r_hcnt     <= '0;
      r_wait     <= '0;
      r_err      <= 2'b00;
      r_abort    <= 1'b0;
      r_busy     <= 1'b0;
      r_xfer     <= 1'b0;
      r_complete <= 1'b0;
      r_req      <= 1'b0;
      r_done     <= 1'b0;
      r_dly      <= 1'b0;
      r_reset    <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt;
      r_hold     <= w_hold;
      r_hcnt     <= w_hcnt;
      r_wait     <= w_wait;
      r_err      <= w_err;
      r_abort    <= w_abort;
      r_busy     <= w_nxt != IDLE;
      r_xfer     <= w_xfer;
      r_complete <= r_state == REL && w_nxt == IDLE;
      r_req      <= w_nxt == REQ;
      r_done     <= w_nxt == FIN && !w_abort;
      r_dly      <= (w_nxt == FIN && w_hold != '0) || w_nxt == HOLD;
      r_reset    <= w_nxt == FIN && w_abort;
    end
  end
  assign busy     = r_busy;
  assign xfer_en  = r_xfer;
  assign complete = r_complete;
  assign err      = r_err;
  assign req      = r_req;
  assign done     = r_done;
  assign dly      = r_dly;
  assign reset    = r_reset;
endmodule
